// File: rtl/pc_sequencer_if.sv
// Fetch/execute control bundle between the PC sequencer and the
// ROM, datapath and program counter around it.
interface pc_sequencer_if;
  logic        rom_req;
  logic        rom_ack;
  logic [15:0] rom_data;
  logic [15:0] instr;
  logic        exec_valid;
  logic        exec_done;
  logic        zr;
  logic        ng;
  logic [15:0] a_value;
  logic [15:0] pc_value;
  logic        pc_reset;
  logic        pc_load;
  logic        pc_inc;
  logic        halted;
  logic        run;

  modport master (
    output rom_req,
    output instr,
    output exec_valid,
    output pc_reset,
    output pc_load,
    output pc_inc,
    output halted,
    input  rom_ack,
    input  rom_data,
    input  exec_done,
    input  zr,
    input  ng,
    input  a_value,
    input  pc_value,
    input  run
  );

  modport slave (
    input  rom_req,
    input  instr,
    input  exec_valid,
    input  pc_reset,
    input  pc_load,
    input  pc_inc,
    input  halted,
    output rom_ack,
    output rom_data,
    output exec_done,
    output zr,
    output ng,
    output a_value,
    output pc_value,
    output run
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute controller for the Hack PC.
// Every output is registered from the next-state decode.
module pc_sequencer #(
  parameter int BOOT_CYCLES = 4
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.master bus
);

  localparam int CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BOOT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_UPDATE,
    S_HALTED
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt;
  logic [15:0]   r_instr;
  logic [15:0]   w_instr;
  logic [15:0]   r_a_s;
  logic [15:0]   w_a_s;
  logic [15:0]   r_pc_s;
  logic [15:0]   w_pc_s;
  logic          r_taken;
  logic          w_taken;
  logic          w_cond;
  logic          w_self;

  logic r_rom_req;
  logic r_exec_valid;
  logic r_pc_reset;
  logic r_pc_load;
  logic r_pc_inc;
  logic r_halted;

  // Jump condition from the C-instruction jump bits and ALU flags
  assign w_cond = r_instr[15] &
                  ((r_instr[2] & bus.ng) |
                   (r_instr[1] & bus.zr) |
                   (r_instr[0] & ~bus.ng & ~bus.zr));

  assign w_self = r_taken &
                  (r_instr[2:0] == 3'b111) &
                  (r_a_s == r_pc_s);

  always_comb begin
    w_next  = r_state;
    w_cnt   = r_cnt;
    w_instr = r_instr;
    w_a_s   = r_a_s;
    w_pc_s  = r_pc_s;
    w_taken = r_taken;
    unique case (r_state)
      S_BOOT: begin
        if (r_cnt == LAST) begin
          w_next = S_FETCH;
          w_cnt  = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_FETCH: begin
        if (bus.rom_ack) begin
          w_instr = bus.rom_data;
          w_next  = S_EXEC;
        end
      end
      S_EXEC: begin
        w_a_s  = bus.a_value;
        w_pc_s = bus.pc_value;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (bus.exec_done) begin
          w_taken = w_cond;
          w_next  = S_UPDATE;
        end
      end
      S_UPDATE: begin
        w_next = w_self ? S_HALTED : S_FETCH;
      end
      S_HALTED: begin
        if (bus.run) w_next = S_FETCH;
      end
      default: begin
        w_next = S_BOOT;
        w_cnt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_BOOT;
      r_cnt        <= '0;
      r_instr      <= '0;
      r_a_s        <= '0;
      r_pc_s       <= '0;
      r_taken      <= 1'b0;
      r_rom_req    <= 1'b0;
      r_exec_valid <= 1'b0;
      r_pc_reset   <= 1'b1;
      r_pc_load    <= 1'b0;
      r_pc_inc     <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= w_cnt;
      r_instr      <= w_instr;
      r_a_s        <= w_a_s;
      r_pc_s       <= w_pc_s;
      r_taken      <= w_taken;
      r_rom_req    <= (w_next == S_FETCH);
      r_exec_valid <= (w_next == S_EXEC);
      r_pc_reset   <= (w_next == S_BOOT);
      r_pc_load    <= (w_next == S_UPDATE) & w_taken;
      r_pc_inc     <= (w_next == S_UPDATE) & ~w_taken;
      r_halted     <= (w_next == S_HALTED);
    end
  end

  assign bus.rom_req    = r_rom_req;
  assign bus.instr      = r_instr;
  assign bus.exec_valid = r_exec_valid;
  assign bus.pc_reset   = r_pc_reset;
  assign bus.pc_load    = r_pc_load;
  assign bus.pc_inc     = r_pc_inc;
  assign bus.halted     = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: per-cycle reference model plus
// directed instruction scenarios with literal expectations.
module tb_pc_sequencer;

  localparam int BOOT = 4;

  localparam int P_BOOT  = 0;
  localparam int P_FETCH = 1;
  localparam int P_EXEC  = 2;
  localparam int P_WAIT  = 3;
  localparam int P_UPD   = 4;
  localparam int P_HALT  = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pc_sequencer_if bus();

  pc_sequencer #(.BOOT_CYCLES(BOOT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ev_cnt = 0;
  int ld_cnt = 0;
  int inc_cnt = 0;
  int rst_cnt = 0;

  task automatic check(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks which phase of the instruction cycle we are in
  int          m_ph = P_BOOT;
  int          m_boot_left = BOOT;
  logic [15:0] m_instr = '0;
  logic [15:0] m_a = '0;
  logic [15:0] m_pc = '0;
  logic        m_take = 1'b0;

  function automatic logic jumps(input logic [15:0] ins,
                                 input logic z, input logic n);
    if (!ins[15]) return 1'b0;
    return (n && ins[2]) || (z && ins[1]) || (!n && !z && ins[0]);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ph = P_BOOT;
      m_boot_left = BOOT;
      m_instr = '0;
      m_take = 1'b0;
    end else begin
      case (m_ph)
        P_BOOT: begin
          m_boot_left = m_boot_left - 1;
          if (m_boot_left == 0) m_ph = P_FETCH;
        end
        P_FETCH: if (bus.rom_ack) begin
          m_instr = bus.rom_data;
          m_ph = P_EXEC;
        end
        P_EXEC: begin
          m_a = bus.a_value;
          m_pc = bus.pc_value;
          m_ph = P_WAIT;
        end
        P_WAIT: if (bus.exec_done) begin
          m_take = jumps(m_instr, bus.zr, bus.ng);
          m_ph = P_UPD;
        end
        P_UPD: begin
          if (m_take && m_instr[2:0] == 3'b111 && m_a == m_pc)
            m_ph = P_HALT;
          else
            m_ph = P_FETCH;
        end
        P_HALT: if (bus.run) m_ph = P_FETCH;
        default: m_ph = P_BOOT;
      endcase
    end
  end

  always @(negedge clk) begin
    check("rom_req", 16'(bus.rom_req), 16'(m_ph == P_FETCH));
    check("exec_valid", 16'(bus.exec_valid), 16'(m_ph == P_EXEC));
    check("pc_reset", 16'(bus.pc_reset), 16'(m_ph == P_BOOT));
    check("pc_load", 16'(bus.pc_load), 16'(m_ph == P_UPD && m_take));
    check("pc_inc", 16'(bus.pc_inc), 16'(m_ph == P_UPD && !m_take));
    check("halted", 16'(bus.halted), 16'(m_ph == P_HALT));
    check("instr", bus.instr, m_instr);
    check("strobe_excl",
          16'($countones({bus.pc_reset, bus.pc_load, bus.pc_inc}) <= 1), 16'd1);
    ev_cnt  += int'(bus.exec_valid);
    ld_cnt  += int'(bus.pc_load);
    inc_cnt += int'(bus.pc_inc);
    rst_cnt += int'(bus.pc_reset);
  end

  task automatic tick();
    @(negedge clk);
    #1;
    bus.rom_data = 16'($urandom);
    if (!bus.exec_done) begin
      bus.zr = 1'($urandom);
      bus.ng = 1'($urandom);
    end
  endtask

  task automatic wait_req(input string nm);
    int k;
    k = 0;
    while (!bus.rom_req && k < 100) begin
      tick();
      k++;
    end
    check(nm, 16'(bus.rom_req), 16'd1);
  endtask

  task automatic boot_seq();
    int r0, l0, i0;
    reset = 1'b0;
    repeat (2) tick();
    @(posedge clk);
    #1;
    reset = 1'b1;
    r0 = rst_cnt;
    l0 = ld_cnt;
    i0 = inc_cnt;
    wait_req("boot_req");
    check("boot_len", 16'(rst_cnt - r0), 16'(BOOT));
    check("boot_nostrobe", 16'((ld_cnt - l0) + (inc_cnt - i0)), 16'd0);
  endtask

  task automatic serve(input logic [15:0] d, input int ackw, input int donew,
                       input logic z, input logic n,
                       input logic [15:0] av, input logic [15:0] pv,
                       input logic early, input logic exp_ld);
    int e0, l0, i0, k;
    e0 = ev_cnt;
    l0 = ld_cnt;
    i0 = inc_cnt;
    if (early) begin
      bus.exec_done = 1'b1;
      bus.zr = z;
      bus.ng = n;
    end
    wait_req("req_seen");
    repeat (ackw) tick();
    bus.rom_ack = 1'b1;
    bus.rom_data = d;
    bus.a_value = av;
    bus.pc_value = pv;
    @(negedge clk);
    #1;
    bus.rom_ack = 1'b0;
    bus.rom_data = 16'($urandom);
    check("instr_lat", bus.instr, d);
    check("ev_pulse", 16'(bus.exec_valid), 16'd1);
    repeat (donew) tick();
    bus.exec_done = 1'b1;
    bus.zr = z;
    bus.ng = n;
    k = 0;
    while (!(bus.pc_load || bus.pc_inc) && k < 100) begin
      tick();
      k++;
    end
    bus.exec_done = 1'b0;
    bus.a_value = 16'($urandom);
    bus.pc_value = 16'($urandom);
    check("ev_count", 16'(ev_cnt - e0), 16'd1);
    check("ld_count", 16'(ld_cnt - l0), 16'(exp_ld));
    check("inc_count", 16'(inc_cnt - i0), 16'(!exp_ld));
  endtask

  task automatic rst_mid(input int where);
    wait_req("rm_req");
    bus.rom_ack = 1'b1;
    bus.rom_data = 16'hE302;
    @(negedge clk);
    #1;
    bus.rom_ack = 1'b0;
    if (where >= 1) tick();
    if (where == 2) begin
      bus.exec_done = 1'b1;
      bus.zr = 1'b1;
      bus.ng = 1'b0;
      tick();
      bus.exec_done = 1'b0;
      check("rm_load_vis", 16'(bus.pc_load), 16'd1);
    end
    #2;
    reset = 1'b0;
    #1;
    check("rm_pc_reset", 16'(bus.pc_reset), 16'd1);
    check("rm_pc_load", 16'(bus.pc_load), 16'd0);
    check("rm_pc_inc", 16'(bus.pc_inc), 16'd0);
    check("rm_exec_valid", 16'(bus.exec_valid), 16'd0);
    check("rm_rom_req", 16'(bus.rom_req), 16'd0);
    check("rm_instr", bus.instr, 16'h0000);
    boot_seq();
  endtask

  initial begin
    bus.rom_ack = 1'b0;
    bus.rom_data = '0;
    bus.exec_done = 1'b0;
    bus.zr = 1'b0;
    bus.ng = 1'b0;
    bus.a_value = '0;
    bus.pc_value = '0;
    bus.run = 1'b0;
    #1;
    reset = 1'b0;
    #2;
    check("rst_pc_reset", 16'(bus.pc_reset), 16'd1);
    check("rst_req", 16'(bus.rom_req), 16'd0);
    boot_seq();

    serve(16'h0005, 3, 0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    serve(16'hE302, 0, 0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    serve(16'hE302, 0, 0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    serve(16'hE302, 1, 2, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    serve(16'hE304, 0, 1, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b1);
    serve(16'hE301, 2, 0, 1'b0, 1'b0, 16'h3, 16'h3, 1'b0, 1'b1);
    serve(16'hEA87, 0, 0, 1'b0, 1'b0, 16'h0020, 16'h0010, 1'b0, 1'b1);
    tick();
    check("jmp_no_halt", 16'(bus.halted), 16'd0);
    check("jmp_refetch", 16'(bus.rom_req), 16'd1);

    bus.run = 1'b1;
    serve(16'h0007, 0, 0, 1'b0, 1'b0, 16'h0005, 16'h0005, 1'b1, 1'b0);
    bus.run = 1'b0;
    tick();
    check("a_no_halt", 16'(bus.halted), 16'd0);

    serve(16'hEA87, 0, 0, 1'b0, 1'b0, 16'h0010, 16'h0010, 1'b0, 1'b1);
    tick();
    check("halt_set", 16'(bus.halted), 16'd1);
    check("halt_noreq", 16'(bus.rom_req), 16'd0);
    repeat (3) tick();
    check("halt_hold", 16'(bus.halted), 16'd1);
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    check("run_unhalt", 16'(bus.halted), 16'd0);
    check("run_req", 16'(bus.rom_req), 16'd1);
    serve(16'h0001, 0, 0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

    rst_mid(0);
    rst_mid(1);
    rst_mid(2);
    serve(16'hE302, 0, 0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
